// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32 execute-stage definitions used by the iterative
//                multiply/divide unit. It provides the datapath width, the
//                M-extension Funct7 code, the Funct3 operation enum and the
//                sequencer state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // The ALU controller decodes this Funct7 value and routes the op here.
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/muldiv_iter_dp.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_dp
//  Description : Iterative datapath for the multiply/divide unit. It works
//                on unsigned operand magnitudes and produces one bit per step:
//                radix-2 shift-add for multiply, restoring division for
//                divide. It has no control state of its own.
//  Ports       : clk, reset   - clock, async active-high reset
//                load_i       - capture operands, clear the remainder
//                step_i       - perform one iteration
//                div_i        - 1: divide step, 0: multiply step
//                op_a_i       - |rs1| (multiplicand / dividend)
//                op_b_i       - |rs2| (multiplier / divisor)
//                prod_o       - unsigned 2*XLEN-bit product
//                quot_o       - unsigned quotient
//                rem_o        - unsigned remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quot_o,
    output logic [XLEN-1:0]   rem_o
);

    // acc_q: multiply -> {partial sum, remaining multiplier bits};
    //        divide   -> lower half shifts dividend bits out and quotient in.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    // Multiplicand for multiply, divisor for divide.
    logic [XLEN-1:0]   opnd_q, opnd_d;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic              w_fits;

    always_comb begin
        w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        // Bring the next dividend bit into the partial remainder; the extra
        // top bit of the difference acts as the borrow of the trial subtract.
        w_shift   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, opnd_q};
        w_fits    = ~w_diff[XLEN+1];
    end

    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        opnd_d = opnd_q;
        if (load_i) begin
            rem_d = '0;
            if (div_i) begin
                opnd_d = op_b_i;
                acc_d  = {{XLEN{1'b0}}, op_a_i};
            end else begin
                opnd_d = op_a_i;
                acc_d  = {{XLEN{1'b0}}, op_b_i};
            end
        end else if (step_i) begin
            if (div_i) begin
                rem_d = w_fits ? w_diff[XLEN:0] : w_shift;
                acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], w_fits};
            end else begin
                acc_d = {w_mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            rem_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            opnd_q <= opnd_d;
        end
    end

    assign prod_o = acc_q;
    assign quot_o = acc_q[XLEN-1:0];
    assign rem_o  = rem_q[XLEN-1:0];

endmodule : muldiv_iter_dp
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative RV32M multiply/divide unit. It holds the
//                sequencing FSM, the divide-by-zero and overflow short cuts,
//                the sign fix-up and the result register.
//  Ports       : clk, reset        - clock, async active-high reset
//                start             - request, sampled in IDLE only
//                flush             - abort the in-flight op
//                Funct3            - M-extension operation select
//                SrcA, SrcB        - rs1 / rs2 values
//                busy              - unit not idle
//                stall             - hold the pipeline while iterating
//                done              - one-cycle result-valid pulse
//                Result            - registered result
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_d;
    logic            neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    muldiv_op_t      w_op;
    logic            w_a_signed, w_b_signed;
    logic            w_sa, w_sb;
    logic [XLEN-1:0] w_abs_a, w_abs_b;
    logic            w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_dp_load, w_dp_step, w_dp_div;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0] w_quot, w_rem, w_fix_res;

    // ---------------- operand conditioning / special cases ----------------
    always_comb begin
        w_op       = muldiv_op_t'(Funct3);
        w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU)
                  || (w_op == OP_DIV) || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MUL) || (w_op == OP_MULH)
                  || (w_op == OP_DIV) || (w_op == OP_REM);
        w_sa       = w_a_signed & SrcA[XLEN-1];
        w_sb       = w_b_signed & SrcB[XLEN-1];
        w_abs_a    = w_sa ? (-SrcA) : SrcA;
        w_abs_b    = w_sb ? (-SrcB) : SrcB;

        w_div_zero = Funct3[2] && (SrcB == '0);
        w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM))
                  && (SrcA == INT_MIN) && (SrcB == ALL_ONES);
        w_special  = w_div_zero || w_ovf;

        // Funct3[1] separates the remainder ops from the quotient ops.
        if (w_div_zero) begin
            w_special_res = Funct3[1] ? SrcA : ALL_ONES;
        end else begin
            w_special_res = Funct3[1] ? {XLEN{1'b0}} : INT_MIN;
        end
    end

    // ---------------- datapath ----------------
    assign w_dp_load = (state_q == IDLE) && start && !flush && !w_special;
    assign w_dp_step = (state_q == CALC);
    // During the load cycle the op is not latched yet, so take it live.
    assign w_dp_div  = (state_q == IDLE) ? Funct3[2] : op_q[2];

    muldiv_iter_dp #(
        .XLEN   (XLEN)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_dp_load),
        .step_i (w_dp_step),
        .div_i  (w_dp_div),
        .op_a_i (w_abs_a),
        .op_b_i (w_abs_b),
        .prod_o (w_prod),
        .quot_o (w_quot),
        .rem_o  (w_rem)
    );

    // ---------------- sign fix-up and result select ----------------
    always_comb begin
        w_prod_fix = neg_q ? (-w_prod) : w_prod;
        if (!op_q[2]) begin
            w_fix_res = (op_q == OP_MUL) ? w_prod_fix[XLEN-1:0]
                                         : w_prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            w_fix_res = neg_q ? (-w_rem) : w_rem;
        end else begin
            w_fix_res = neg_q ? (-w_quot) : w_quot;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (w_special) begin
                        result_d = w_special_res;
                        state_d  = DONE;
                    end else begin
                        op_d    = w_op;
                        // The remainder takes the dividend's sign only.
                        neg_d   = (Funct3[2:1] == 2'b11) ? w_sa : (w_sa ^ w_sb);
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = w_fix_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transition and leaves Result untouched.
        if (flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign stall  = ((state_q == IDLE) && start && !w_special)
                 || (busy && (state_q != DONE));
    assign Result = result_q;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Directed self-checking bench for muldiv_sequencer. Cycle 0
//                is the cycle in which start is presented; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] Result;

    int n_checks;
    int n_errors;

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one op from IDLE and check stall at accept, done cycle, Result,
    // stall in the DONE cycle and that done is a single pulse.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] exp_res);
        int got_cyc;
        logic [31:0] got_res;
        logic got_stall;
        got_cyc   = -1;
        got_res   = '0;
        got_stall = 1'b1;
        @(negedge clk);
        Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
        #1 check({tag, "_stall0"}, 32'(stall), (exp_cyc == 1) ? 32'd0 : 32'd1);
        @(negedge clk);
        // Operand changes after acceptance must not matter.
        start = 1'b0; SrcA = ~a; SrcB = ~b; Funct3 = ~f3;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                got_cyc   = c;
                got_res   = Result;
                got_stall = stall;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_cyc"}, 32'(got_cyc), 32'(exp_cyc));
        check({tag, "_res"}, got_res, exp_res);
        check({tag, "_stallD"}, 32'(got_stall), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {28'd0, busy, stall, done, 1'b0}, 32'd0);
        check("rst_res", Result, 32'd0);
        reset = 1'b0;

        // MUL 7x6 with busy checked in cycle 1.
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mul_busy1", 32'(busy), 32'd1);
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                check("mul_cyc", 32'(c), 32'd34);
                check("mul_res", Result, 32'd42);
                check("mul_stallD", 32'(stall), 32'd0);
                ndone++;
            end
            @(negedge clk);
        end
        check("mul_ndone", 32'(ndone), 32'd1);

        run_op("mulneg", 3'b000, 32'hFFFFFFFD, 32'd5,        34, 32'hFFFFFFF1);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000000);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        34, 32'hFFFFFFFF);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFD);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF);
        run_op("divu",   3'b101, 32'd100,      32'd7,        34, 32'd14);
        run_op("remu",   3'b111, 32'd100,      32'd7,        34, 32'd2);
        run_op("div0",   3'b100, 32'd5,        32'd0,        1,  32'hFFFFFFFF);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        1,  32'd5);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1,  32'd0);
        run_op("divu2",  3'b101, 32'd1000,     32'd8,        34, 32'd125);

        // Flush at cycle 10 of a MUL; a start while busy is also presented.
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) begin start = 1'b1; Funct3 = 3'b101; end
            if (c == 6) start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy11", 32'(busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush_ndone", 32'(ndone), 32'd0);
        check("flush_res", Result, 32'd125);

        // A start while busy is ignored: exactly one done, first op's result.
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            if (done) ndone++;
            if (c == 5) begin start = 1'b1; SrcA = 32'd2; SrcB = 32'd2; end
            if (c == 6) start = 1'b0;
            @(negedge clk);
        end
        check("busy_ndone", 32'(ndone), 32'd1);
        check("busy_res", Result, 32'd81);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("arst_outs", {29'd0, busy, stall, done}, 32'd0);
        check("arst_res", Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 3'b101, 32'd9, 32'd3, 34, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire
